// File: rtl/cnt_share_pkg.sv
// Shared types and sizing helpers for the shared wide-counter controller.
package cnt_share_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        START = 2'd1,
        STOP  = 2'd2,
        SNAP  = 2'd3
    } cmd_e;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_e;

    // Number of OUT_W-bit beats needed to carry a CNT_W-bit snapshot.
    function automatic int unsigned nbeat_f(input int unsigned cnt_w, input int unsigned out_w);
        return (cnt_w + out_w - 1) / out_w;
    endfunction

    // Requester-id width, never narrower than one bit.
    function automatic int unsigned idw_f(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, and
// reports the pointer position just past the winner.
module rr_arbiter
    import cnt_share_pkg::*;
#(
    parameter  int unsigned N  = 3,
    localparam int unsigned PW = idw_f(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          accept,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] next_ptr
);

    logic          found;
    logic [PW-1:0] idx;

    // Scan requesters starting at ptr and pick the first one asserting req.
    always_comb begin
        gnt      = '0;
        next_ptr = ptr;
        found    = 1'b0;
        idx      = '0;
        if (accept) begin
            for (int unsigned k = 0; k < N; k++) begin
                idx = PW'((32'(ptr) + k) % N);
                if (!found && req[idx]) begin
                    found    = 1'b1;
                    gnt[idx] = 1'b1;
                    next_ptr = (idx == PW'(N - 1)) ? '0 : idx + PW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/cnt_share_ctrl.sv
// Shared wide free-running counter with round-robin command arbitration
// and a narrow LSB-first snapshot readout port.
// Build option: define CNT_SHARE_SAT_EN to make the counter saturate at
// all-ones (wrapped then means "saturated") instead of wrapping modulo 2^CNT_W.
module cnt_share_ctrl
    import cnt_share_pkg::*;
#(
    parameter  int unsigned CNT_W = 121,
    parameter  int unsigned NREQ  = 3,
    parameter  int unsigned OUT_W = 14,
    localparam int unsigned NBEAT = nbeat_f(CNT_W, OUT_W),
    localparam int unsigned IDW   = idw_f(NREQ)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [2*NREQ-1:0] req_cmd,
    output logic [NREQ-1:0]   req_ready,
    output logic              rd_valid,
    output logic [OUT_W-1:0]  rd_data,
    output logic              rd_last,
    output logic [IDW-1:0]    rd_id,
    input  logic              rd_ready,
    output logic              running,
    output logic              wrapped,
    output logic              busy
);

    localparam int unsigned BW   = (NBEAT > 1) ? $clog2(NBEAT) : 1;
    localparam int unsigned PADW = NBEAT * OUT_W;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             running_q, running_d;
    logic             wrapped_q, wrapped_d;
    state_e           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic [IDW-1:0]   rd_id_q, rd_id_d;

    logic             arb_en;
    logic [NREQ-1:0]  gnt;
    logic             fire;
    logic [IDW-1:0]   gidx;
    cmd_e             gcmd;
    logic [PADW-1:0]  beat_shift;

    // Grants are only offered in IDLE and never while reset is asserted.
    assign arb_en = (state_q == IDLE) && !reset;

    rr_arbiter #(.N(NREQ)) u_arb (
        .req      (req_valid),
        .ptr      (rr_ptr_q),
        .accept   (arb_en),
        .gnt      (gnt),
        .next_ptr (rr_ptr_d)
    );

    assign req_ready = gnt;
    assign fire      = |gnt;

    // Encode the one-hot grant into an index and select that requester's command.
    always_comb begin
        gidx = '0;
        gcmd = CLEAR;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                gidx = IDW'(i);
                gcmd = cmd_e'(req_cmd[2*i +: 2]);
            end
        end
    end

    // Counter advance, overflow tracking and command side effects.
    always_comb begin
        cnt_d     = cnt_q;
        running_d = running_q;
        wrapped_d = wrapped_q;
        if (running_q) begin
`ifdef CNT_SHARE_SAT_EN
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
                if (&cnt_d) wrapped_d = 1'b1;
            end
`else
            cnt_d = cnt_q + CNT_W'(1);
            if (&cnt_q) wrapped_d = 1'b1;
`endif
        end
        if (fire) begin
            case (gcmd)
                CLEAR: begin
                    cnt_d     = '0;
                    wrapped_d = 1'b0;
                end
                START:   running_d = 1'b1;
                STOP:    running_d = 1'b0;
                default: ;
            endcase
        end
    end

    // Snapshot capture on SNAP, then beat sequencing through READ.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        beat_d   = beat_q;
        rd_id_d  = rd_id_q;
        case (state_q)
            IDLE: begin
                if (fire && gcmd == SNAP) begin
                    shadow_d = cnt_q;
                    rd_id_d  = gidx;
                    beat_d   = '0;
                    state_d  = READ;
                end
            end
            READ: begin
                if (rd_ready) begin
                    if (beat_q == BW'(NBEAT - 1)) state_d = IDLE;
                    else                          beat_d  = beat_q + BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset aborts any readout in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            running_q <= 1'b0;
            wrapped_q <= 1'b0;
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            shadow_q  <= '0;
            beat_q    <= '0;
            rd_id_q   <= '0;
        end else begin
            cnt_q     <= cnt_d;
            running_q <= running_d;
            wrapped_q <= wrapped_d;
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            shadow_q  <= shadow_d;
            beat_q    <= beat_d;
            rd_id_q   <= rd_id_d;
        end
    end

    // Zero-extending the shadow makes the final beat's upper bits read as zero.
    assign beat_shift = PADW'(shadow_q) >> (32'(beat_q) * OUT_W);

    assign rd_valid = (state_q == READ);
    assign rd_data  = rd_valid ? beat_shift[OUT_W-1:0] : '0;
    assign rd_last  = rd_valid && (beat_q == BW'(NBEAT - 1));
    assign rd_id    = rd_id_q;
    assign running  = running_q;
    assign wrapped  = wrapped_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_cnt_share_ctrl.sv
module tb_cnt_share_ctrl;
    import cnt_share_pkg::*;

    localparam int unsigned CNT_W = 121;
    localparam int unsigned NREQ  = 3;
    localparam int unsigned OUT_W = 14;
    localparam int unsigned NBEAT = 9;
    localparam int unsigned IDW   = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [2*NREQ-1:0] req_cmd;
    logic [NREQ-1:0]   req_ready;
    logic              rd_valid;
    logic [OUT_W-1:0]  rd_data;
    logic              rd_last;
    logic [IDW-1:0]    rd_id;
    logic              rd_ready;
    logic              running;
    logic              wrapped;
    logic              busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [CNT_W-1:0]       force_val;
    logic [CNT_W-1:0]       maxv;
    logic [CNT_W-1:0]       pat_p;
    logic [NBEAT*OUT_W-1:0] val;
    logic [NBEAT*OUT_W-1:0] val2;
    int                     cyc_a;
    int                     w;

    cnt_share_ctrl #(.CNT_W(CNT_W), .NREQ(NREQ), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_cmd   (req_cmd),
        .req_ready (req_ready),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .rd_id     (rd_id),
        .rd_ready  (rd_ready),
        .running   (running),
        .wrapped   (wrapped),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        rd_ready  = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Present one command from requester r, expect an immediate grant, and
    // return at the falling edge after the accept edge with valid dropped.
    task automatic issue(input int r, input logic [1:0] cmd, input string tag);
        req_valid[r]       = 1'b1;
        req_cmd[2*r +: 2]  = cmd;
        #1;
        chk({tag, "_gnt"}, 128'(req_ready), 128'(1 << r));
        @(posedge clk);
        @(negedge clk);
        req_valid[r] = 1'b0;
    endtask

    task automatic load_cnt(input logic [CNT_W-1:0] v);
        force_val = v;
        force dut.cnt_d = force_val;
        @(posedge clk);
        @(negedge clk);
        release dut.cnt_d;
    endtask

    // Drain one snapshot with rd_ready following pat (bit 0 first, repeating).
    task automatic read_all(input logic [3:0] pat, input string tag,
                            output logic [NBEAT*OUT_W-1:0] v);
        int               beats = 0;
        int               pi    = 0;
        logic             stalled = 1'b0;
        logic [OUT_W-1:0] pd = '0;
        logic             pl = 1'b0;
        v = '0;
        for (int c = 0; c < 100; c++) begin
            rd_ready = pat[pi];
            pi = (pi + 1) % 4;
            #1;
            if (!rd_valid) break;
            if (stalled) begin
                chk({tag, "_stall_data"}, 128'(rd_data), 128'(pd));
                chk({tag, "_stall_last"}, 128'(rd_last), 128'(pl));
            end
            if (rd_ready) begin
                chk({tag, "_last"}, 128'(rd_last), 128'(beats == NBEAT - 1));
                if (rd_last) chk({tag, "_no_gnt_on_last"}, 128'(req_ready), 128'(0));
                if (beats < NBEAT) v[beats*OUT_W +: OUT_W] = rd_data;
                beats++;
            end
            stalled = !rd_ready;
            pd      = rd_data;
            pl      = rd_last;
            @(negedge clk);
        end
        chk({tag, "_beats"}, 128'(beats), 128'(NBEAT));
        rd_ready = 1'b1;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 3'b111;
        req_cmd   = '0;
        rd_ready  = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 128'(req_ready), 128'(0));
        chk("rst_rd_valid",  128'(rd_valid),  128'(0));
        chk("rst_rd_last",   128'(rd_last),   128'(0));
        chk("rst_rd_data",   128'(rd_data),   128'(0));
        chk("rst_rd_id",     128'(rd_id),     128'(0));
        chk("rst_busy",      128'(busy),      128'(0));
        chk("rst_running",   128'(running),   128'(0));
        chk("rst_wrapped",   128'(wrapped),   128'(0));
        chk("rst_cnt",       128'(dut.cnt_q), 128'(0));
        req_valid = '0;
        reset     = 1'b0;

        // Basic START then SNAP after 20 counts.
        issue(0, START, "t1_start");
        cyc_a = cyc;
        chk("t1_running", 128'(running), 128'(1));
        chk("t1_cnt0", 128'(dut.cnt_q), 128'(0));
        repeat (20) @(negedge clk);
        chk("t1_cnt20", 128'(dut.cnt_q), 128'(20));
        issue(0, SNAP, "t1_snap");
        chk("t1_rd_valid", 128'(rd_valid), 128'(1));
        chk("t1_busy", 128'(busy), 128'(1));
        chk("t1_rd_id", 128'(rd_id), 128'(0));
        chk("t1_no_gnt_in_read", 128'(req_ready), 128'(0));
        read_all(4'b1111, "t1", val);
        chk("t1_beat0", 128'(val[OUT_W-1:0]), 128'(20));
        chk("t1_upper", 128'(val >> OUT_W), 128'(0));
        chk("t1_idle_busy", 128'(busy), 128'(0));

        // Three simultaneous SNAPs served in round-robin order.
        do_reset();
        req_cmd   = {SNAP, SNAP, SNAP};
        req_valid = 3'b111;
        #1;
        for (int g = 0; g < 3; g++) begin
            w = 0;
            while (req_ready == '0 && w < 40) begin
                @(negedge clk);
                #1;
                w++;
            end
            chk("t2_grant", 128'(req_ready), 128'(1 << g));
            @(posedge clk);
            @(negedge clk);
            req_valid[g] = 1'b0;
            #1;
            chk("t2_rd_id", 128'(rd_id), 128'(g));
            chk("t2_hold_off", 128'(req_ready), 128'(0));
            read_all(4'b1111, "t2", val);
            chk("t2_data", 128'(val), 128'(0));
        end

        // Wrap (or saturation) at the top of the counter range.
        do_reset();
        maxv = '1;
        load_cnt(maxv - CNT_W'(1));
        chk("t3_loaded", 128'(dut.cnt_q), 128'(maxv - CNT_W'(1)));
        chk("t3_wrapped0", 128'(wrapped), 128'(0));
        issue(0, START, "t3_start");
        repeat (3) @(negedge clk);
`ifdef CNT_SHARE_SAT_EN
        chk("t3_sat_cnt", 128'(dut.cnt_q), 128'(maxv));
        chk("t3_sat_flag", 128'(wrapped), 128'(1));
        repeat (2) @(negedge clk);
        chk("t3_sat_hold", 128'(dut.cnt_q), 128'(maxv));
`else
        chk("t3_wrap_cnt", 128'(dut.cnt_q), 128'(1));
        chk("t3_wrap_flag", 128'(wrapped), 128'(1));
`endif

        // CLEAR while running with wrapped set, then STOP holds the count.
        issue(1, CLEAR, "t6_clear");
        chk("t6_cnt0", 128'(dut.cnt_q), 128'(0));
        chk("t6_wrapped0", 128'(wrapped), 128'(0));
        chk("t6_still_running", 128'(running), 128'(1));
        repeat (4) @(negedge clk);
        chk("t6_cnt4", 128'(dut.cnt_q), 128'(4));
        issue(2, STOP, "t6_stop");
        chk("t6_stopped", 128'(running), 128'(0));
        chk("t6_cnt5", 128'(dut.cnt_q), 128'(5));
        repeat (3) @(negedge clk);
        chk("t6_cnt_hold", 128'(dut.cnt_q), 128'(5));
        issue(0, SNAP, "t6_snap1");
        read_all(4'b1111, "t6a", val);
        issue(1, SNAP, "t6_snap2");
        read_all(4'b1111, "t6b", val2);
        chk("t6_snap1_val", 128'(val), 128'(5));
        chk("t6_snap2_val", 128'(val2), 128'(5));
        chk("t6_snaps_equal", 128'(val), 128'(val2));

        // Stalled readout with rd_ready pattern 1,0,0,1 on a rich snapshot.
        do_reset();
        pat_p = 121'h1_0123_4567_89AB_CDEF_FEDC_BA98_7654_32;
        load_cnt(pat_p);
        issue(0, START, "t4_start");
        cyc_a = cyc;
        repeat (5) @(negedge clk);
        issue(0, SNAP, "t4_snap");
        read_all(4'b1001, "t4", val);
        chk("t4_data", 128'(val), 128'(pat_p + CNT_W'(5)));
        chk("t4_cnt_continues", 128'(dut.cnt_q), 128'(pat_p + CNT_W'(cyc - cyc_a)));
        chk("t4_running", 128'(running), 128'(1));

        // Reset in the middle of a readout.
        do_reset();
        issue(0, START, "t5_start");
        repeat (3) @(negedge clk);
        issue(0, SNAP, "t5_snap");
        rd_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("t5_mid_valid", 128'(rd_valid), 128'(1));
        chk("t5_mid_last", 128'(rd_last), 128'(0));
        reset = 1'b1;
        @(negedge clk);
        chk("t5_rd_valid", 128'(rd_valid), 128'(0));
        chk("t5_busy", 128'(busy), 128'(0));
        chk("t5_cnt", 128'(dut.cnt_q), 128'(0));
        chk("t5_running", 128'(running), 128'(0));
        reset = 1'b0;
        issue(0, SNAP, "t5_resnap");
        chk("t5_rd_id", 128'(rd_id), 128'(0));
        read_all(4'b1111, "t5", val);
        chk("t5_zero", 128'(val), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cnt_share_ctrl.md
Name: cnt_share_ctrl

Overview:
- Owns one wide free-running counter and shares its control among NREQ requesters.
- Round-robin arbitration picks one command at a time: CLEAR, START, STOP or SNAP.
- SNAP captures the counter into a shadow register, then streams it out LSB-first in OUT_W-bit beats on a valid/ready read port.
- Sits between per-domain control logic and the wide-counter datapath; drives a narrow output bus instead of exposing all CNT_W bits.

Parameters:
- CNT_W, 121, counter width in bits.
- NREQ, 3, number of requesters.
- OUT_W, 14, readout beat width.
- NBEAT, ceil(CNT_W/OUT_W) = 9, derived; not overridable.
- IDW, max(1, clog2(NREQ)), derived requester-id width.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  NREQ  per-requester command valid.
- req_cmd  in  2*NREQ  per-requester command; slice i = bits [2i+1:2i]; 0 CLEAR, 1 START, 2 STOP, 3 SNAP.
- req_ready  out  NREQ  one-hot grant/accept; a command transfers when valid&ready.
- rd_valid  out  1  readout beat valid.
- rd_data  out  OUT_W  readout beat.
- rd_last  out  1  marks the final beat.
- rd_id  out  IDW  index of the requester that issued the SNAP.
- rd_ready  in  1  readout sink ready.
- running  out  1  counter run flag.
- wrapped  out  1  sticky overflow flag.
- busy  out  1  high when the FSM is not in IDLE.

Behaviour:
- Single clock domain. Synchronous active-high reset gives: cnt=0, running=0, wrapped=0, state=IDLE, rr_ptr=0, req_ready=0, rd_valid=0, rd_last=0, rd_data=0, rd_id=0.
- Counter: cnt <= cnt+1 every cycle while running=1. On wrap from all-ones to 0, wrapped <= 1; it stays set until CLEAR.
- FSM states: IDLE and READ only.
- IDLE, no requests: req_ready=0.
- IDLE, any req_valid: combinational round-robin grant starting at rr_ptr; req_ready[g]=1 for that cycle only. On the accept edge, rr_ptr <= (g+1) mod NREQ. Non-granted requesters must hold valid.
- CLEAR: cnt<=0 and wrapped<=0 at the accept edge; running unchanged; stay in IDLE.
- START: running<=1; no effect if already running.
- STOP: running<=0; cnt holds its current value.
- SNAP: shadow <= cnt (pre-increment value at the accept edge), rd_id<=g, beat<=0, go to READ.
- Accept latency: one command per cycle at most. The effect is visible the cycle after acceptance.
- READ: req_ready=0 for all requesters; counter keeps running.
  - rd_valid=1.
  - rd_data = shadow[beat*OUT_W +: OUT_W].
  - Final beat (beat=NBEAT-1) is zero-padded: default carries 9 valid LSBs and 5 zero MSBs.
  - rd_last=1 on that beat.
  - Beat advances only on rd_valid&rd_ready. The beat after last returns to IDLE with rd_valid=0.
  - First rd_valid appears the cycle after SNAP acceptance.
- rd_ready low: rd_data, rd_last and rd_id hold stable.
- Back-to-back: a new grant can occur the cycle after returning to IDLE, never in the same cycle as the last beat.
- Reset during READ: readout aborts immediately and all reset values apply. A partially delivered snapshot is not resumed.
- req_valid on an invalid requester index is impossible by construction. Any 2-bit cmd value is legal.

Optional Feature:
- Macro CNT_SHARE_SAT_EN.
- Defined: the counter saturates at all-ones. The cycle it reaches all-ones, wrapped <= 1, now meaning "saturated"; cnt holds until CLEAR.
- Undefined: modulo-2^CNT_W wrap as described above.
- Port list is identical in both builds.

Decomposition:
- Package cnt_share_pkg holds:
  - cmd_e enum: CLEAR, START, STOP, SNAP.
  - state_e enum: IDLE, READ.
  - Constant functions for NBEAT and IDW.
- Sub-module rr_arbiter (parameter N): inputs req[N], ptr, accept; outputs one-hot gnt and next_ptr. It is reused by the wider-counter variants.
- Counter, shadow register and readout mux stay in cnt_share_ctrl.

Test Plan:
- Reset, then START from req0, wait 20 cycles, SNAP from req0 with rd_ready=1. Required: 9 beats; beat0 = 20 or 21 exactly per the accept-edge rule (checked against the model); beats 1..8 = 0; rd_last only on beat 8; rd_id=0.
- req0, req1, req2 all assert SNAP simultaneously. Required: grants in order 0,1,2, each after the previous readout completes; rd_id sequence 0,1,2.
- Force cnt=2^121-2 via a bench backdoor, START, wait 3 cycles. Required: wrapped=1 and cnt=1. Repeat under CNT_SHARE_SAT_EN: cnt=all-ones, held; wrapped=1.
- SNAP readout with rd_ready toggling 1,0,0,1. Required: data held stable while stalled; no beat skipped or duplicated; counter continues incrementing throughout.
- Reset asserted at beat 4 of a readout. Required: next cycle rd_valid=0, busy=0, cnt=0, running=0; a following SNAP reads all zeros.
- CLEAR while running with wrapped=1. Required: cnt=0 and wrapped=0 the next cycle, running stays 1; STOP then gives a cnt hold, verified by two SNAPs returning equal values.
